// File: rtl/uart_reg_fifo.sv
// Memory-mapped UART register block: TX/RX FIFOs, baud divisor, control/status,
// sticky overflow flags and a registered level interrupt.
module uart_reg_fifo #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 8,
  parameter logic [31:0] DVSR_RST = 32'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic              read_enable,
  input  logic [4:0]        address,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [31:0]       dvsr,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              irq
);

  localparam int unsigned TXP_W = $clog2(TX_DEPTH);
  localparam int unsigned TXC_W = TXP_W + 1;
  localparam int unsigned RXP_W = $clog2(RX_DEPTH);
  localparam int unsigned RXC_W = RXP_W + 1;

  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_DVSR   = 3'd1,
    REG_CTRL   = 3'd2,
    REG_STATUS = 3'd3,
    REG_CLEAR  = 3'd4,
    REG_RSV5   = 3'd5,
    REG_RSV6   = 3'd6,
    REG_RSV7   = 3'd7
  } reg_idx_e;

  reg_idx_e idx;
  logic     unused_addr;
  assign idx         = reg_idx_e'(address[4:2]);
  assign unused_addr = ^address[1:0];

  logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
  logic [TXP_W-1:0]  tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [RXP_W-1:0]  rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [TXC_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [RXC_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [31:0]       dvsr_q, dvsr_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic              tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d, irq_q, irq_d;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push_req, tx_push, tx_pop, rx_push_req, rx_push, rx_pop;
  logic [DATA_W-1:0] rx_head;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == TXC_W'(TX_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RXC_W'(RX_DEPTH));

  assign tx_valid    = ctrl_q[0] & ~tx_empty;
  assign tx_pop      = tx_valid & tx_ready;
  assign tx_push_req = write_enable & (idx == REG_DATA);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);

  assign rx_pop      = read_enable & (idx == REG_DATA) & ~rx_empty;
  assign rx_push_req = rx_valid & ctrl_q[1];
  assign rx_push     = rx_push_req & (~rx_full | rx_pop);

  assign tx_data = tx_empty ? '0 : tx_mem_q[tx_rp_q];
  assign rx_head = rx_empty ? '0 : rx_mem_q[rx_rp_q];
  assign dvsr    = dvsr_q;
  assign irq     = irq_q;

  always_comb begin
    tx_wp_d  = tx_push ? tx_wp_q + TXP_W'(1) : tx_wp_q;
    tx_rp_d  = tx_pop  ? tx_rp_q + TXP_W'(1) : tx_rp_q;
    rx_wp_d  = rx_push ? rx_wp_q + RXP_W'(1) : rx_wp_q;
    rx_rp_d  = rx_pop  ? rx_rp_q + RXP_W'(1) : rx_rp_q;
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    dvsr_d   = dvsr_q;
    ctrl_d   = ctrl_q;
    tx_ovf_d = tx_ovf_q;
    rx_ovr_d = rx_ovr_q;

    unique case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + TXC_W'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - TXC_W'(1);
      default: ;
    endcase
    unique case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + RXC_W'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - RXC_W'(1);
      default: ;
    endcase

    if (write_enable) begin
      if (idx == REG_DVSR) dvsr_d = wdata;
      if (idx == REG_CTRL) ctrl_d = wdata[3:0];
      if (idx == REG_CLEAR) begin
        if (wdata[4]) tx_ovf_d = 1'b0;
        if (wdata[5]) rx_ovr_d = 1'b0;
      end
    end
    // Sets are applied after clears so a same-cycle overflow survives CLEAR.
    if (tx_push_req && !tx_push) tx_ovf_d = 1'b1;
    if (rx_push_req && !rx_push) rx_ovr_d = 1'b1;

    irq_d = (ctrl_q[2] & tx_empty) | (ctrl_q[3] & ~rx_empty) | tx_ovf_q | rx_ovr_q;
  end

  always_comb begin
    rdata = '0;
    unique case (idx)
      REG_DATA: begin
        rdata[31]         = ~rx_empty;
        rdata[DATA_W-1:0] = rx_head;
      end
      REG_DVSR:   rdata = dvsr_q;
      REG_CTRL:   rdata[3:0] = ctrl_q;
      REG_STATUS: begin
        rdata[0]     = tx_full;
        rdata[1]     = tx_empty;
        rdata[2]     = rx_full;
        rdata[3]     = rx_empty;
        rdata[4]     = tx_ovf_q;
        rdata[5]     = rx_ovr_q;
        rdata[15:8]  = 8'(tx_cnt_q);
        rdata[23:16] = 8'(rx_cnt_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && tx_push) tx_mem_q[tx_wp_q] <= wdata[DATA_W-1:0];
    if (!rst && rx_push) rx_mem_q[rx_wp_q] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      dvsr_q   <= DVSR_RST;
      ctrl_q   <= '0;
      tx_ovf_q <= 1'b0;
      rx_ovr_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      dvsr_q   <= dvsr_d;
      ctrl_q   <= ctrl_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovr_q <= rx_ovr_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_uart_reg_fifo.sv
// Self-checking bench for uart_reg_fifo: directed scenarios then random traffic,
// all compared against a queue-based model of the register map.
module tb_uart_reg_fifo;

  localparam int unsigned DW  = 8;
  localparam int unsigned TXD = 8;
  localparam int unsigned RXD = 8;
  localparam logic [31:0] DRST = 32'h0000_0145;

  logic          clk = 1'b0;
  logic          rst, we, re, tx_ready, rx_valid;
  logic [4:0]    addr;
  logic [31:0]   wdata, rdata, dvsr_o;
  logic [DW-1:0] tx_data, rx_data;
  logic          tx_valid, irq;

  uart_reg_fifo #(.DATA_W(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .DVSR_RST(DRST)) dut (
    .clk(clk), .rst(rst), .write_enable(we), .read_enable(re), .address(addr),
    .wdata(wdata), .rdata(rdata), .dvsr(dvsr_o), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] m_tx[$];
  logic [DW-1:0] m_rx[$];
  logic [31:0]   m_dvsr;
  logic [3:0]    m_ctrl;
  bit            m_ovf, m_ovr;
  logic          m_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rdata(input logic [4:0] a);
    logic [31:0] r;
    r = '0;
    case (a[4:2])
      3'd0: if (m_rx.size() != 0) r = {1'b1, 23'd0, m_rx[0]};
      3'd1: r = m_dvsr;
      3'd2: r = {28'd0, m_ctrl};
      3'd3: begin
        r[0]     = (m_tx.size() == TXD);
        r[1]     = (m_tx.size() == 0);
        r[2]     = (m_rx.size() == RXD);
        r[3]     = (m_rx.size() == 0);
        r[4]     = m_ovf;
        r[5]     = m_ovr;
        r[15:8]  = 8'(m_tx.size());
        r[23:16] = 8'(m_rx.size());
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // One clock: check combinational read data, advance the model, then check outputs.
  task automatic cycle();
    bit t_req, t_pop, t_full, r_req, r_pop, r_full;
    logic irq_next;
    #1;
    if (!rst) check("rdata", rdata, exp_rdata(addr));
    if (rst) begin
      m_tx.delete(); m_rx.delete();
      m_dvsr = DRST; m_ctrl = '0; m_ovf = 0; m_ovr = 0; irq_next = 1'b0;
    end else begin
      irq_next = (m_ctrl[2] && m_tx.size() == 0) || (m_ctrl[3] && m_rx.size() != 0) || m_ovf || m_ovr;
      t_req  = we && addr[4:2] == 3'd0;
      t_pop  = m_ctrl[0] && m_tx.size() != 0 && tx_ready;
      t_full = m_tx.size() == TXD;
      r_req  = rx_valid && m_ctrl[1];
      r_pop  = re && addr[4:2] == 3'd0 && m_rx.size() != 0;
      r_full = m_rx.size() == RXD;
      if (we && addr[4:2] == 3'd4) begin
        if (wdata[4]) m_ovf = 0;
        if (wdata[5]) m_ovr = 0;
      end
      if (we && addr[4:2] == 3'd1) m_dvsr = wdata;
      if (we && addr[4:2] == 3'd2) m_ctrl = wdata[3:0];
      if (t_pop) void'(m_tx.pop_front());
      if (t_req) begin
        if (!t_full || t_pop) m_tx.push_back(wdata[DW-1:0]); else m_ovf = 1;
      end
      if (r_pop) void'(m_rx.pop_front());
      if (r_req) begin
        if (!r_full || r_pop) m_rx.push_back(rx_data); else m_ovr = 1;
      end
    end
    @(posedge clk); #1;
    m_irq = irq_next;
    check("tx_valid", tx_valid, (m_ctrl[0] && m_tx.size() != 0));
    check("tx_data", tx_data, (m_tx.size() != 0) ? m_tx[0] : '0);
    check("irq", irq, m_irq);
    check("dvsr", dvsr_o, m_dvsr);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1; addr = a; wdata = d;
    cycle();
    we = 0; wdata = '0;
  endtask

  task automatic rd(input logic [4:0] a);
    re = 1; addr = a;
    cycle();
    re = 0;
  endtask

  task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr = a; #1;
    check(tag, rdata, exp);
    check({tag, "_model"}, rdata, exp_rdata(a));
  endtask

  task automatic push_rx(input logic [DW-1:0] d);
    rx_valid = 1; rx_data = d;
    cycle();
    rx_valid = 0;
  endtask

  initial begin
    rst = 1; we = 0; re = 0; tx_ready = 0; rx_valid = 0; addr = '0; wdata = '0; rx_data = '0;
    m_dvsr = DRST; m_ctrl = '0; m_irq = 1'b0;
    cycle();
    rst = 0;
    peek("reset_status", 5'h0C, 32'h0000_000A);
    check("reset_dvsr", dvsr_o, DRST);
    check("reset_tx_valid", tx_valid, 1'b0);
    check("reset_irq", irq, 1'b0);
    peek("reserved_rd", 5'h14, 32'h0);

    // TX fill to full, then one overflowing write
    wr(5'h08, 32'h1);
    for (int i = 0; i < 8; i++) wr(5'h00, 32'h41 + i);
    peek("tx_full_status", 5'h0C, 32'h0000_0809);
    wr(5'h00, 32'h49);
    peek("tx_ovf_status", 5'h0C, 32'h0000_0819);
    cycle();
    check("tx_ovf_irq", irq, 1'b1);

    // TX drain in order
    tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check("tx_drain_data", tx_data, 32'h41 + i);
      cycle();
    end
    tx_ready = 0;
    check("tx_drain_valid", tx_valid, 1'b0);
    wr(5'h10, 32'h10);
    peek("tx_empty_status", 5'h0C, 32'h0000_000A);

    // RX path and empty read
    wr(5'h08, 32'h3);
    push_rx(8'h55);
    push_rx(8'hAA);
    addr = 5'h00; #1; check("rx_rd0", rdata, 32'h8000_0055);
    rd(5'h00);
    check("rx_rd1", rdata, 32'h8000_00AA);
    rd(5'h00);
    check("rx_rd2", rdata, 32'h0000_0000);
    rd(5'h00);

    // RX overrun and write-1-to-clear
    for (int i = 0; i < 9; i++) push_rx(8'(8'h10 + i));
    peek("rx_ovr_status", 5'h0C, 32'h0008_0026);
    cycle();
    check("rx_ovr_irq", irq, 1'b1);
    wr(5'h10, 32'h20);
    peek("rx_ovr_clear", 5'h0C, 32'h0008_0006);
    // overrun and CLEAR in the same cycle: flag stays set
    rx_valid = 1; rx_data = 8'hEE;
    wr(5'h10, 32'h20);
    rx_valid = 0;
    peek("set_wins", 5'h0C, 32'h0008_0026);
    wr(5'h10, 32'h20);
    for (int i = 0; i < 8; i++) rd(5'h00);
    cycle(); cycle();
    check("irq_quiet", irq, 1'b0);

    // Full TX with simultaneous write and pop
    wr(5'h08, 32'h0);
    tx_ready = 1;
    for (int i = 0; i < 8; i++) wr(5'h00, 32'h60 + i);
    check("tx_en_gate", tx_valid, 1'b0);
    tx_ready = 0;
    wr(5'h08, 32'h1);
    tx_ready = 1;
    wr(5'h00, 32'h99);
    tx_ready = 0;
    peek("tx_wr_pop_status", 5'h0C, 32'h0000_0809);
    tx_ready = 1;
    for (int i = 0; i < 7; i++) cycle();
    check("tx_new_byte", tx_data, 32'h99);
    cycle();
    tx_ready = 0;

    // TX-empty interrupt enable
    wr(5'h08, 32'h4);
    cycle();
    check("irq_txe", irq, 1'b1);

    // Reset in the middle of traffic
    wr(5'h04, 32'hDEAD_BEEF);
    wr(5'h08, 32'h3);
    wr(5'h00, 32'h33);
    push_rx(8'h44);
    rst = 1; we = 1; addr = 5'h00; wdata = 32'h77; rx_valid = 1; rx_data = 8'h88;
    cycle();
    rst = 0; we = 0; rx_valid = 0;
    peek("mid_rst_status", 5'h0C, 32'h0000_000A);
    check("mid_rst_dvsr", dvsr_o, DRST);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      rst      = ($urandom_range(0, 99) == 0);
      we       = ($urandom_range(0, 2) == 0);
      re       = ($urandom_range(0, 2) == 0);
      addr     = {3'($urandom_range(0, 7)), 2'($urandom)};
      wdata    = $urandom;
      if (we && addr[4:2] == 3'd2) wdata[1:0] = 2'b11;
      tx_ready = ($urandom_range(0, 1) == 1);
      rx_valid = ($urandom_range(0, 1) == 1);
      rx_data  = DW'($urandom);
      cycle();
    end
    rst = 0; we = 0; re = 0; tx_ready = 0; rx_valid = 0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
